// File: rtl/riscv_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_fetch_unit                                                           |
// | Instruction fetch front end: issues word requests, buffers instruction/PC  |
// | pairs in a credit-limited prefetch queue, hands them to decode.            |
// | Optional feature macro: FETCH_JAL_PREDECODE_EN (JAL predecode redirect).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module riscv_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_SUM_W = c_CNT_W + 1;
    localparam logic [c_SUM_W-1:0] c_DEPTH_SUM  = c_SUM_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT  = c_CNT_W'(DEPTH);
    localparam logic [31:0]        c_WORD_MASK  = 32'hFFFF_FFFC;

    logic [31:0]        r_fetch_pc_q, w_fetch_pc_d;
    logic [31:0]        r_rsp_pc_q, w_rsp_pc_d;
    logic [c_CNT_W-1:0] r_outstanding_q, w_outstanding_d;
    logic [c_CNT_W-1:0] r_discard_q, w_discard_d;
    logic [c_CNT_W-1:0] r_count_q, w_count_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [31:0]        r_instr_mem_q [DEPTH];
    logic [31:0]        r_pc_mem_q    [DEPTH];

    logic [31:0] w_redirect_pc;
    logic [31:0] w_jal_target;
    logic        w_jal_redirect;
    logic        w_credit_ok;
    logic        w_req_fire;
    logic        w_push;
    logic        w_pop;
    logic        w_full;

    // Stale in-flight requests still hold a credit until their response drains.
    assign w_credit_ok   = ({1'b0, r_count_q} + {1'b0, r_outstanding_q}) < c_DEPTH_SUM;
    assign w_redirect_pc = redirect_pc & c_WORD_MASK;
    assign w_push        = imem_rsp_valid && (r_discard_q == '0) && !redirect_valid;
    assign w_pop         = if_valid && if_ready && !redirect_valid;
    assign w_full        = (r_count_q == c_DEPTH_CNT);

`ifdef FETCH_JAL_PREDECODE_EN
    localparam logic [6:0] c_OPC_JAL = 7'b1101111;
    assign w_jal_redirect = w_push && (imem_rsp_data[6:0] == c_OPC_JAL);
    assign w_jal_target   = (r_rsp_pc_q + {{11{imem_rsp_data[31]}}, imem_rsp_data[31],
                             imem_rsp_data[19:12], imem_rsp_data[20],
                             imem_rsp_data[30:21], 1'b0}) & c_WORD_MASK;
`else
    assign w_jal_redirect = 1'b0;
    assign w_jal_target   = r_rsp_pc_q;
`endif

    assign imem_req_valid = !reset && !redirect_valid && !w_jal_redirect && w_credit_ok;
    assign imem_req_addr  = r_fetch_pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign if_valid = (r_count_q != '0);
    assign if_instr = if_valid ? r_instr_mem_q[r_rd_ptr_q] : '0;
    assign if_pc    = if_valid ? r_pc_mem_q[r_rd_ptr_q]    : '0;

    always_comb begin
        w_fetch_pc_d    = r_fetch_pc_q;
        w_rsp_pc_d      = r_rsp_pc_q;
        w_outstanding_d = r_outstanding_q + c_CNT_W'(w_req_fire) - c_CNT_W'(imem_rsp_valid);
        w_discard_d     = r_discard_q;
        w_count_d       = r_count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        w_rd_ptr_d      = r_rd_ptr_q + c_PTR_W'(w_pop);
        w_wr_ptr_d      = r_wr_ptr_q + c_PTR_W'(w_push);

        if (w_req_fire) begin
            w_fetch_pc_d = r_fetch_pc_q + 32'd4;
        end
        if (w_push) begin
            w_rsp_pc_d = r_rsp_pc_q + 32'd4;
        end
        if (imem_rsp_valid && (r_discard_q != '0)) begin
            w_discard_d = r_discard_q - 1'b1;
        end

        // Everything still in flight after this cycle belongs to the old path.
        if (redirect_valid) begin
            w_fetch_pc_d = w_redirect_pc;
            w_rsp_pc_d   = w_redirect_pc;
            w_discard_d  = r_outstanding_q - c_CNT_W'(imem_rsp_valid);
            w_count_d    = '0;
            w_rd_ptr_d   = '0;
            w_wr_ptr_d   = '0;
        end else if (w_jal_redirect) begin
            w_fetch_pc_d = w_jal_target;
            w_rsp_pc_d   = w_jal_target;
            w_discard_d  = r_outstanding_q - c_CNT_W'(imem_rsp_valid);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc_q    <= RESET_PC;
            r_rsp_pc_q      <= RESET_PC;
            r_outstanding_q <= '0;
            r_discard_q     <= '0;
            r_count_q       <= '0;
            r_rd_ptr_q      <= '0;
            r_wr_ptr_q      <= '0;
        end else begin
            r_fetch_pc_q    <= w_fetch_pc_d;
            r_rsp_pc_q      <= w_rsp_pc_d;
            r_outstanding_q <= w_outstanding_d;
            r_discard_q     <= w_discard_d;
            r_count_q       <= w_count_d;
            r_rd_ptr_q      <= w_rd_ptr_d;
            r_wr_ptr_q      <= w_wr_ptr_d;
        end
    end

    // Queue storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_instr_mem_q[r_wr_ptr_q] <= imem_rsp_data;
            r_pc_mem_q[r_wr_ptr_q]    <= r_rsp_pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(w_push && w_full));

endmodule
`default_nettype wire
